uart_tx_periph: RTL and testbench

//  Memory-mapped UART transmitter on the CPU data bus, beside the LED GPO port.

---
 rtl/uart_tx_periph.sv | 211 +++++++++++++++++++++
 tb/tb_uart_tx_periph.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: CPU byte stores feed a TX FIFO that is serialised 8N1, LSB first.
// Define UART_PARITY_EN to insert an even parity bit between the data and stop bits.
module uart_tx_periph #(
    parameter logic [9:0] BASE_ADDR    = 10'h3F0,
    parameter int         CLKS_PER_BIT = 104,
    parameter int         FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  address,
    input  logic [31:0] data_in,
    input  logic [3:0]  width,
    input  logic        write,
    output logic [31:0] rd_data,
    output logic        tx,
    output logic        tx_irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [9:0]    STATUS_ADDR = BASE_ADDR + 10'd4;
    localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state, state_next;
    logic [BW-1:0] baud, baud_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shift, shift_next;
    logic          tx_next;
    logic          baud_last;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          overflow;
    logic          push_req, push, pop, full, empty, ovf_clear;
    logic          unused_bits;

`ifdef UART_PARITY_EN
    logic parity;
`endif

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign baud_last = (baud == BAUD_LAST);
    assign push_req  = write && (address == BASE_ADDR) && width[0];
    // A full FIFO still accepts a push when the same edge frees a slot
    assign push      = push_req && (!full || pop);
    assign ovf_clear = write && (address == STATUS_ADDR) && width[0] && data_in[3];
    assign unused_bits = ^{data_in[31:8], width[3:1]};

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_comb begin
        state_next   = state;
        baud_next    = baud;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        tx_next      = tx;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    baud_next  = '0;
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_next    = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                    tx_next      = shift[0];
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_next = PARITY;
                        tx_next    = parity;
`else
                        state_next = STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                        shift_next   = shift >> 1;
                        tx_next      = shift[1];
                    end
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    baud_next  = '0;
                    state_next = STOP;
                    tx_next    = 1'b1;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    baud_next = '0;
                    // Chain straight into the next start bit so queued frames have no idle gap
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            tx_irq   <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            baud     <= baud_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
            tx       <= tx_next;
            tx_irq   <= (state_next == IDLE) && (count_next == '0);
            count    <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (ovf_clear) begin
                overflow <= 1'b0;
            end else if (push_req && !push) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity <= 1'b0;
        end else if (pop) begin
            parity <= ^mem[rd_ptr];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in[7:0];
        end
    end

    always_comb begin
        rd_data = '0;
        if (address == STATUS_ADDR) begin
            rd_data[0]      = (state != IDLE);
            rd_data[1]      = full;
            rd_data[2]      = empty;
            rd_data[3]      = overflow;
            rd_data[8 +: CW] = count;
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph: vector table, directed frame sequences and a
// randomized bus run compared against a frame-level queue model of the transmitter.
module tb_uart_tx_periph;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam logic [9:0] TXDATA = 10'h3F0;
    localparam logic [9:0] STATUS = 10'h3F4;
    localparam logic [9:0] OTHER  = 10'h100;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [9:0]  address = '0;
    logic [31:0] data_in = '0;
    logic [3:0]  width = '0;
    logic        write = 1'b0;
    logic [31:0] rd_data;
    logic        tx;
    logic        tx_irq;

    int vectors = 0;
    int miscompares = 0;

    uart_tx_periph #(
        .BASE_ADDR   (TXDATA),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .address(address),
        .data_in(data_in),
        .width  (width),
        .write  (write),
        .rd_data(rd_data),
        .tx     (tx),
        .tx_irq (tx_irq)
    );

    always #5 clk = ~clk;

    // Reference model: queue of accepted bytes plus the frame currently on the line
    logic [7:0]  m_q[$];
    bit          m_active = 1'b0;
    int          m_elapsed = 0;
    logic [10:0] m_bits = '1;
    bit          m_ovf = 1'b0;

    function automatic logic [10:0] frameBits(input logic [7:0] d);
        logic [10:0] f = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_PARITY_EN
        f[9] = ^d;
`endif
        return f;
    endfunction

    task automatic modelReset();
        m_q.delete();
        m_active  = 1'b0;
        m_elapsed = 0;
        m_ovf     = 1'b0;
    endtask

    task automatic modelEdge(input logic wr, input logic [9:0] addr, input logic [3:0] wid,
                             input logic [31:0] data);
        int pre_size = m_q.size();
        bit pop = 1'b0;
        if (!m_active) begin
            pop = (pre_size != 0);
        end else if (m_elapsed == FRAME_CYC - 1) begin
            pop = (pre_size != 0);
            if (!pop) m_active = 1'b0;
        end else begin
            m_elapsed++;
        end
        if (pop) begin
            m_bits    = frameBits(m_q.pop_front());
            m_active  = 1'b1;
            m_elapsed = 0;
        end
        if (wr && addr == TXDATA && wid[0]) begin
            if (pre_size < DEPTH || pop) m_q.push_back(data[7:0]);
            else m_ovf = 1'b1;
        end
        if (wr && addr == STATUS && wid[0] && data[3]) m_ovf = 1'b0;
    endtask

    function automatic logic expTx();
        return m_active ? m_bits[m_elapsed / CPB] : 1'b1;
    endfunction

    function automatic logic [31:0] expRd(input logic [9:0] addr);
        logic [31:0] s = '0;
        if (addr == STATUS) begin
            s[0]    = m_active;
            s[1]    = (m_q.size() == DEPTH);
            s[2]    = (m_q.size() == 0);
            s[3]    = m_ovf;
            s[12:8] = 5'(m_q.size());
        end
        return s;
    endfunction

    // Line decoder: counts start bits seen while not inside a frame
    int rx_frames = 0;
    int rx_left = 0;
    always @(negedge clk) begin
        if (rx_left == 0) begin
            if (rst_n && tx == 1'b0) begin
                rx_frames++;
                rx_left = FRAME_CYC - 1;
            end
        end else begin
            rx_left--;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [9:0] addr, input logic [3:0] wid,
                                 input logic [31:0] data);
        write   = wr;
        address = addr;
        width   = wid;
        data_in = data;
        @(posedge clk);
        modelEdge(wr, addr, wid, data);
        #1;
        checkOutput("tx", {31'b0, tx}, {31'b0, expTx()});
        checkOutput("tx_irq", {31'b0, tx_irq}, {31'b0, (!m_active && m_q.size() == 0)});
        checkOutput("rd_data", rd_data, expRd(addr));
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, STATUS, 4'b0000, 32'h0);
    endtask

    task automatic resetDut();
        write   = 1'b0;
        address = STATUS;
        rst_n   = 1'b0;
        #1;
        checkOutput("reset_tx", {31'b0, tx}, 32'd1);
        checkOutput("reset_irq", {31'b0, tx_irq}, 32'd1);
        checkOutput("reset_status", rd_data, 32'h0000_0004);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic waitDrain(input int limit);
        for (int i = 0; i < limit && tx_irq !== 1'b1; i++) idleCycle();
        checkOutput("drained", {31'b0, tx_irq}, 32'd1);
    endtask

    task automatic frameCheck(input logic [7:0] d);
        logic [10:0] f = frameBits(d);
        applyStimulus(1'b1, TXDATA, 4'b0001, {24'h0, d});
        checkOutput("frame_push_hold", {31'b0, tx}, 32'd1);
        for (int c = 0; c < FRAME_CYC; c++) begin
            idleCycle();
            checkOutput("frame_bit", {31'b0, tx}, {31'b0, f[c / CPB]});
            checkOutput("frame_irq_busy", {31'b0, tx_irq}, 32'd0);
        end
        idleCycle();
        checkOutput("frame_irq_done", {31'b0, tx_irq}, 32'd1);
    endtask

`ifdef UART_PARITY_EN
    task automatic parityCheck(input logic [7:0] d, input logic exp_par);
        applyStimulus(1'b1, TXDATA, 4'b0001, {24'h0, d});
        for (int c = 0; c < FRAME_CYC; c++) begin
            idleCycle();
            if (c == 9 * CPB + CPB / 2) checkOutput("parity_bit", {31'b0, tx}, {31'b0, exp_par});
            if (c == FRAME_CYC - 1) checkOutput("parity_frame_busy", {31'b0, tx_irq}, 32'd0);
        end
        idleCycle();
        checkOutput("parity_frame_end", {31'b0, tx_irq}, 32'd1);
    endtask
`endif

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [3:0]  wid;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_tx;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int r;
        logic [3:0] w;
        logic [9:0] a;

        vecs[0] = '{1'b0, STATUS, 4'b0000, 32'h0000_0000, 32'h0000_0004, 1'b1, 1'b1};
        vecs[1] = '{1'b1, TXDATA, 4'b0010, 32'h0000_0055, 32'h0000_0000, 1'b1, 1'b1};
        vecs[2] = '{1'b0, STATUS, 4'b0000, 32'h0000_0000, 32'h0000_0004, 1'b1, 1'b1};
        vecs[3] = '{1'b1, STATUS, 4'b0001, 32'h0000_0008, 32'h0000_0004, 1'b1, 1'b1};
        vecs[4] = '{1'b1, TXDATA, 4'b1111, 32'hFFFF_FF55, 32'h0000_0000, 1'b1, 1'b0};
        vecs[5] = '{1'b0, STATUS, 4'b0000, 32'h0000_0000, 32'h0000_0005, 1'b0, 1'b0};
        vecs[6] = '{1'b0, STATUS, 4'b0000, 32'h0000_0000, 32'h0000_0005, 1'b0, 1'b0};

        #2;
        resetDut();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wid, vecs[i].data);
            checkOutput("tbl_rd", rd_data, vecs[i].exp_rd);
            checkOutput("tbl_tx", {31'b0, tx}, {31'b0, vecs[i].exp_tx});
            checkOutput("tbl_irq", {31'b0, tx_irq}, {31'b0, vecs[i].exp_irq});
        end
        waitDrain(2 * FRAME_CYC);

        $display("[TB] single frame 8'h55");
        frameCheck(8'h55);

        $display("[TB] back-to-back frames");
        rx_frames = 0;
        applyStimulus(1'b1, TXDATA, 4'b0001, 32'h0000_00A1);
        applyStimulus(1'b1, TXDATA, 4'b0001, 32'h0000_00B2);
        checkOutput("b2b_first_start", {31'b0, tx}, 32'd0);
        for (int c = 1; c < 2 * FRAME_CYC; c++) begin
            idleCycle();
            if (c == FRAME_CYC - 1) checkOutput("b2b_stop1", {31'b0, tx}, 32'd1);
            if (c == FRAME_CYC) checkOutput("b2b_start2", {31'b0, tx}, 32'd0);
        end
        waitDrain(FRAME_CYC);
        checkOutput("b2b_frames", rx_frames, 32'd2);

        $display("[TB] overflow");
        rx_frames = 0;
        applyStimulus(1'b1, TXDATA, 4'b0001, 32'h0000_0011);
        idleCycle();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, TXDATA, 4'b0001, 32'h22 + 32'(i) * 32'h11);
        idleCycle();
        checkOutput("ovf_status", rd_data, 32'h0000_040B);
        applyStimulus(1'b1, STATUS, 4'b0001, 32'h0000_0008);
        checkOutput("ovf_cleared", rd_data, 32'h0000_0403);
        waitDrain(6 * FRAME_CYC);
        checkOutput("ovf_frames", rx_frames, 32'd5);

        $display("[TB] ignored byte lane");
        applyStimulus(1'b1, TXDATA, 4'b0010, 32'h0000_00AB);
        idleCycle();
        checkOutput("lane_status", rd_data, 32'h0000_0004);
        repeat (3) idleCycle();
        checkOutput("lane_tx", {31'b0, tx}, 32'd1);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, TXDATA, 4'b0001, 32'h0000_0000);
        for (int c = 0; c < 3 * CPB + 1; c++) idleCycle();
        checkOutput("pre_reset_tx", {31'b0, tx}, 32'd0);
        #2;
        resetDut();
        rx_frames = 0;
        idleCycle();
        checkOutput("post_reset_status", rd_data, 32'h0000_0004);
        for (int c = 0; c < 2 * FRAME_CYC; c++) idleCycle();
        checkOutput("post_reset_frames", rx_frames, 32'd0);

`ifdef UART_PARITY_EN
        $display("[TB] parity");
        parityCheck(8'h07, 1'b1);
        parityCheck(8'h03, 1'b0);
`endif

        $display("[TB] randomized bus traffic");
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            w = 4'($urandom_range(0, 15));
            if (r < ((i / 300) % 2 == 0 ? 10 : 2)) begin
                applyStimulus(1'b1, TXDATA, w, $urandom);
            end else if (r < 13) begin
                applyStimulus(1'b1, STATUS, w, $urandom);
            end else begin
                case ($urandom_range(0, 2))
                    0: a = TXDATA;
                    1: a = STATUS;
                    default: a = OTHER;
                endcase
                applyStimulus(1'b0, a, w, $urandom);
            end
        end
        waitDrain((DEPTH + 2) * FRAME_CYC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
